mem_arbiter: RTL and testbench

//  Shares the single data-memory port between instruction fetch (IFU) and load/store (LSU).

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between IFU fetches and LSU loads/stores, one transaction at a time.
// Optional macro ARB_RR_EN selects round-robin grant; the default build uses fixed LSU priority.
module mem_arbiter #(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [31:0]       ifu_resp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [31:0]       lsu_req_wdata,
    input  logic [1:0]        lsu_req_size,
    input  logic              lsu_req_sext,
    output logic              lsu_resp_valid,
    output logic [31:0]       lsu_resp_data,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_suffix_b,
    output logic              mem_suffix_h,
    output logic              mem_sext,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on any cycle where valid and ready are both high.
    // Ready is only ever raised in IDLE and only for the granted requester.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t             state, state_nxt;
    logic               pick_lsu;
    logic               hs;
    logic               owner_lsu;
    logic               wen_q;
    logic [1:0]         size_q;
    logic               sext_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        data_q;
    logic               access_last;

`ifdef ARB_RR_EN
    logic last_lsu;

    // On a tie the requester not granted last wins.
    assign pick_lsu = lsu_req_valid & (~ifu_req_valid | ~last_lsu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu <= 1'b0;
        end else if (hs) begin
            last_lsu <= pick_lsu;
        end
    end
`else
    assign pick_lsu = lsu_req_valid;
`endif

    assign lsu_req_ready = (state == IDLE) & pick_lsu;
    assign ifu_req_ready = (state == IDLE) & ifu_req_valid & ~pick_lsu;
    assign hs            = lsu_req_ready | ifu_req_ready;
    assign access_last   = (state == ACCESS) & (wen_q | (cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ACCESS;
            ACCESS:  if (access_last) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch; memory address/data registers only move on a handshake so they hold between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_lsu <= 1'b0;
            wen_q     <= 1'b0;
            size_q    <= 2'b00;
            sext_q    <= 1'b0;
            cnt       <= '0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else if (hs) begin
            owner_lsu <= pick_lsu;
            cnt       <= CNT_W'(MEM_LAT - 1);
            if (pick_lsu) begin
                wen_q  <= lsu_req_wen;
                size_q <= lsu_req_size;
                sext_q <= lsu_req_sext;
                if (lsu_req_wen) begin
                    mem_waddr <= lsu_req_addr;
                    mem_wdata <= lsu_req_wdata;
                end else begin
                    mem_raddr <= lsu_req_addr;
                end
            end else begin
                wen_q     <= 1'b0;
                size_q    <= 2'b10;
                sext_q    <= 1'b0;
                mem_raddr <= ifu_req_addr;
            end
        end else if ((state == ACCESS) && !wen_q && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (access_last) begin
            data_q <= wen_q ? 32'd0 : mem_rdata;
        end
    end

    // Memory strobes decode straight from state so an async reset drops them at once.
    assign mem_ren      = (state == ACCESS) & ~wen_q;
    assign mem_wen      = (state == ACCESS) & wen_q;
    assign mem_suffix_b = (state == ACCESS) & (size_q == 2'b00);
    assign mem_suffix_h = (state == ACCESS) & (size_q == 2'b01);
    assign mem_sext     = (state == ACCESS) & ~wen_q & sext_q & ~size_q[1];

    assign ifu_resp_valid = (state == RESP) & ~owner_lsu;
    assign lsu_resp_valid = (state == RESP) & owner_lsu;
    assign ifu_resp_data  = ifu_resp_valid ? data_q : 32'd0;
    assign lsu_resp_data  = lsu_resp_valid ? data_q : 32'd0;

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance for most scenarios, MEM_LAT=3 instance for latency.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_req_addr, ifu_resp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_req_sext, lsu_resp_valid;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
    logic [1:0]  lsu_req_size;
    logic        mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic        b_ifu_req_valid, b_ifu_req_ready, b_ifu_resp_valid;
    logic [31:0] b_ifu_req_addr, b_ifu_resp_data;
    logic        b_lsu_req_valid, b_lsu_req_ready, b_lsu_req_wen, b_lsu_req_sext, b_lsu_resp_valid;
    logic [31:0] b_lsu_req_addr, b_lsu_req_wdata, b_lsu_resp_data;
    logic [1:0]  b_lsu_req_size;
    logic        b_mem_ren, b_mem_wen, b_mem_suffix_b, b_mem_suffix_h, b_mem_sext;
    logic [31:0] b_mem_raddr, b_mem_waddr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_arbiter #(.MEM_LAT(1), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_size(lsu_req_size),
        .lsu_req_sext(lsu_req_sext), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_suffix_b(mem_suffix_b), .mem_suffix_h(mem_suffix_h),
        .mem_sext(mem_sext), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_arbiter #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(b_ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_req_addr(b_ifu_req_addr),
        .ifu_resp_valid(b_ifu_resp_valid), .ifu_resp_data(b_ifu_resp_data),
        .lsu_req_valid(b_lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_req_addr(b_lsu_req_addr),
        .lsu_req_wen(b_lsu_req_wen), .lsu_req_wdata(b_lsu_req_wdata), .lsu_req_size(b_lsu_req_size),
        .lsu_req_sext(b_lsu_req_sext), .lsu_resp_valid(b_lsu_resp_valid), .lsu_resp_data(b_lsu_resp_data),
        .mem_ren(b_mem_ren), .mem_raddr(b_mem_raddr), .mem_wen(b_mem_wen), .mem_waddr(b_mem_waddr),
        .mem_wdata(b_mem_wdata), .mem_suffix_b(b_mem_suffix_b), .mem_suffix_h(b_mem_suffix_h),
        .mem_sext(b_mem_sext), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_size = 0; lsu_req_sext = 0; mem_rdata = 0;
        b_ifu_req_valid = 0; b_ifu_req_addr = 0;
        b_lsu_req_valid = 0; b_lsu_req_addr = 0; b_lsu_req_wen = 0; b_lsu_req_wdata = 0;
        b_lsu_req_size = 0; b_lsu_req_sext = 0; b_mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else pass_cnt++;
        total_cnt++; if ({mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext} !== 5'b0)
            $display("FAIL reset_mem_ctl got %b exp 00000", {mem_ren, mem_wen, mem_suffix_b, mem_suffix_h, mem_sext}); else pass_cnt++;
        total_cnt++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'd0) $display("FAIL reset_mem_bus got %h exp 0", {mem_raddr, mem_waddr, mem_wdata}); else pass_cnt++;
        total_cnt++; if ({ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready} !== 4'b0)
            $display("FAIL reset_handshake got %b exp 0000", {ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}); else pass_cnt++;
    endtask

    task automatic test_ifu_fetch();
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; mem_rdata = 32'h0000_0413;
        #1;
        total_cnt++; if (ifu_req_ready !== 1'b1) $display("FAIL fetch_ready got %b exp 1", ifu_req_ready); else pass_cnt++;
        step(); ifu_req_valid = 0;
        total_cnt++; if (mem_ren !== 1'b1 || mem_raddr !== 32'h8000_0000)
            $display("FAIL fetch_ren got ren=%b addr=%h exp ren=1 addr=80000000", mem_ren, mem_raddr); else pass_cnt++;
        total_cnt++; if (ifu_req_ready !== 1'b0) $display("FAIL fetch_no_ready_access got %b exp 0", ifu_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0000_0413 || lsu_resp_valid !== 1'b0)
            $display("FAIL fetch_resp got v=%b d=%h lv=%b exp v=1 d=00000413 lv=0", ifu_resp_valid, ifu_resp_data, lsu_resp_valid); else pass_cnt++;
        total_cnt++; if (mem_ren !== 1'b0) $display("FAIL fetch_ren_off got %b exp 0", mem_ren); else pass_cnt++;
        step();
        total_cnt++; if (ifu_resp_valid !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL fetch_pulse_end got v=%b st=%0d exp v=0 st=0", ifu_resp_valid, dbg_state); else pass_cnt++;
    endtask

    task automatic test_store_byte();
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0010; lsu_req_wen = 1;
        lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_size = 2'b00; lsu_req_sext = 0;
        #1;
        total_cnt++; if (lsu_req_ready !== 1'b1) $display("FAIL store_ready got %b exp 1", lsu_req_ready); else pass_cnt++;
        step(); lsu_req_valid = 0;
        total_cnt++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_waddr !== 32'h8000_0010 || mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL store_access got wen=%b ren=%b a=%h d=%h exp wen=1 ren=0 a=80000010 d=deadbeef", mem_wen, mem_ren, mem_waddr, mem_wdata); else pass_cnt++;
        total_cnt++; if (mem_suffix_b !== 1'b1 || mem_suffix_h !== 1'b0)
            $display("FAIL store_suffix got b=%b h=%b exp b=1 h=0", mem_suffix_b, mem_suffix_h); else pass_cnt++;
        total_cnt++; if (mem_raddr !== 32'h8000_0000) $display("FAIL raddr_hold got %h exp 80000000", mem_raddr); else pass_cnt++;
        step();
        total_cnt++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'd0 || mem_wen !== 1'b0 || mem_suffix_b !== 1'b0)
            $display("FAIL store_ack got v=%b d=%h wen=%b sb=%b exp v=1 d=0 wen=0 sb=0", lsu_resp_valid, lsu_resp_data, mem_wen, mem_suffix_b); else pass_cnt++;
        step();
    endtask

    task automatic test_load_half_sext();
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0022; lsu_req_wen = 0;
        lsu_req_size = 2'b01; lsu_req_sext = 1; mem_rdata = 32'hFFFF_8001;
        step(); lsu_req_valid = 0;
        total_cnt++; if (mem_ren !== 1'b1 || mem_suffix_h !== 1'b1 || mem_sext !== 1'b1 || mem_suffix_b !== 1'b0)
            $display("FAIL load_half_pins got ren=%b h=%b sx=%b b=%b exp 1 1 1 0", mem_ren, mem_suffix_h, mem_sext, mem_suffix_b); else pass_cnt++;
        total_cnt++; if (mem_waddr !== 32'h8000_0010 || mem_raddr !== 32'h8000_0022)
            $display("FAIL load_half_addr got wa=%h ra=%h exp wa=80000010 ra=80000022", mem_waddr, mem_raddr); else pass_cnt++;
        step();
        total_cnt++; if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'hFFFF_8001 || mem_sext !== 1'b0)
            $display("FAIL load_half_resp got v=%b d=%h sx=%b exp v=1 d=ffff8001 sx=0", lsu_resp_valid, lsu_resp_data, mem_sext); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_lsu;
        apply_reset();
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_req_addr = 32'h8000_0200; lsu_req_wen = 0;
        lsu_req_size = 2'b10; lsu_req_sext = 0; mem_rdata = 32'h1234_5678;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
            exp_lsu = (t % 2 == 0);
`else
            exp_lsu = 1'b1;
`endif
            #1;
            total_cnt++; if (lsu_req_ready !== exp_lsu || ifu_req_ready !== !exp_lsu)
                $display("FAIL b2b_grant%0d got lsu=%b ifu=%b exp lsu=%b ifu=%b", t, lsu_req_ready, ifu_req_ready, exp_lsu, !exp_lsu); else pass_cnt++;
            step();
            step();
            total_cnt++; if (lsu_resp_valid !== exp_lsu || ifu_resp_valid !== !exp_lsu)
                $display("FAIL b2b_resp%0d got lsu=%b ifu=%b exp lsu=%b ifu=%b", t, lsu_resp_valid, ifu_resp_valid, exp_lsu, !exp_lsu); else pass_cnt++;
            @(posedge clk);
        end
        #1;
        ifu_req_valid = 0; lsu_req_valid = 0;
        step();
    endtask

    task automatic test_latency3();
        b_lsu_req_valid = 1; b_lsu_req_addr = 32'h8000_0040; b_lsu_req_wen = 0;
        b_lsu_req_size = 2'b10; b_lsu_req_sext = 1; b_mem_rdata = 32'hCAFE_F00D;
        #1;
        total_cnt++; if (b_lsu_req_ready !== 1'b1) $display("FAIL lat3_ready got %b exp 1", b_lsu_req_ready); else pass_cnt++;
        step();
        for (int c = 1; c <= 3; c++) begin
            total_cnt++; if (b_mem_ren !== 1'b1 || b_lsu_req_ready !== 1'b0 || b_lsu_resp_valid !== 1'b0 || b_mem_sext !== 1'b0)
                $display("FAIL lat3_access%0d got ren=%b rdy=%b rv=%b sx=%b exp 1 0 0 0", c, b_mem_ren, b_lsu_req_ready, b_lsu_resp_valid, b_mem_sext); else pass_cnt++;
            step();
        end
        total_cnt++; if (b_lsu_resp_valid !== 1'b1 || b_lsu_resp_data !== 32'hCAFE_F00D || b_mem_ren !== 1'b0 || b_lsu_req_ready !== 1'b0)
            $display("FAIL lat3_resp got v=%b d=%h ren=%b rdy=%b exp v=1 d=cafef00d ren=0 rdy=0", b_lsu_resp_valid, b_lsu_resp_data, b_mem_ren, b_lsu_req_ready); else pass_cnt++;
        step();
        total_cnt++; if (b_lsu_req_ready !== 1'b1 || b_lsu_resp_valid !== 1'b0)
            $display("FAIL lat3_idle got rdy=%b rv=%b exp rdy=1 rv=0", b_lsu_req_ready, b_lsu_resp_valid); else pass_cnt++;
        b_lsu_req_valid = 0;
        step();
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0300; mem_rdata = 32'h0BAD_0BAD;
        step(); ifu_req_valid = 0;
        total_cnt++; if (mem_ren !== 1'b1) $display("FAIL rst_mid_pre got %b exp 1", mem_ren); else pass_cnt++;
        rst_n = 0;
        #1;
        total_cnt++; if (mem_ren !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL rst_mid_drop got ren=%b st=%0d exp ren=0 st=0", mem_ren, dbg_state); else pass_cnt++;
        step();
        total_cnt++; if (ifu_resp_valid !== 1'b0) $display("FAIL rst_mid_noresp got %b exp 0", ifu_resp_valid); else pass_cnt++;
        rst_n = 1;
        step();
        total_cnt++; if (ifu_resp_valid !== 1'b0 || dbg_state !== 2'd0 || mem_raddr !== 32'd0)
            $display("FAIL rst_mid_after got rv=%b st=%0d ra=%h exp rv=0 st=0 ra=0", ifu_resp_valid, dbg_state, mem_raddr); else pass_cnt++;
        ifu_req_valid = 1;
        #1;
        total_cnt++; if (ifu_req_ready !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", ifu_req_ready); else pass_cnt++;
        step(); ifu_req_valid = 0;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_store_byte();
        test_load_half_sext();
        test_latency3();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
